dbm_slot_engine: RTL and testbench

//  Parametrised, handshaked successor to the datapath byte/word multiplexer.

---
 rtl/dbm_slot_pkg.sv | 23 ++
 rtl/dbm_slot_insert.sv | 28 ++
 rtl/dbm_slot_engine.sv | 150 +++++++++++++++
 tb/tb_dbm_slot_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbm_slot_pkg.sv
// Shared encodings for the DBM slot engine: op codes, pack FSM states, index-width helper.
// Pure declarations, no logic; safe to import from any block in the slice.
// No handshake of its own.
package dbm_slot_pkg;

  typedef enum logic [1:0] {
    OP_SEL     = 2'd0,
    OP_DEPOSIT = 2'd1,
    OP_REPL    = 2'd2,
    OP_PACK    = 2'd3
  } op_e;

  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_FILL = 1'b1
  } pk_state_e;

  // Index widths never collapse to zero, so a single slot/source still has a 1-bit select.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbm_slot_insert.sv
// Replaces one SLOTW-bit slot of a word with a byte; slot >= NSLOT passes the word through.
// Purely combinational, zero latency.
// No handshake; the caller owns flow control.
module dbm_slot_insert
  import dbm_slot_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int SLOTW = 7,
  parameter int NSLOT = 5,
  parameter int SLW   = 3
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SLW-1:0]   slot,
  input  logic [SLOTW-1:0] data,
  output logic [WIDTH-1:0] result
);

  // Bit 0 of the word is the MSB, so slot k starts at vector index WIDTH-1-k*SLOTW.
  always_comb begin
    result = word;
    for (int k = 0; k < NSLOT; k++) begin
      if (int'(slot) == k) begin
        result[WIDTH-1-k*SLOTW -: SLOTW] = data;
      end
    end
  end

endmodule

// File: rtl/dbm_slot_engine.sv
// Source select / byte deposit / byte replicate / byte pack engine feeding the DBM consumer.
// Latency 1 for SEL/DEPOSIT/REPL; PACK emits on the beat that fills the word or flushes.
// in_ready = !out_valid | out_ready; a held output freezes all state.
module dbm_slot_engine
  import dbm_slot_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int SLOTW = 7,
  parameter int NSLOT = 5,
  parameter int NSRC  = 8,
  localparam int SELW = idx_w(NSRC),
  localparam int SLW  = idx_w(NSLOT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [SELW-1:0]       in_sel,
  input  logic [SLW-1:0]        in_slot,
  input  logic [SLOTW-1:0]      in_byte,
  input  logic                  in_flush,
  input  logic [NSRC*WIDTH-1:0] in_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SLW:0]          out_count
);

  generate
    if (NSLOT * SLOTW > WIDTH) begin : g_bad_geometry
      $error("dbm_slot_engine: NSLOT*SLOTW exceeds WIDTH");
    end
  endgenerate

  localparam logic [SLW:0] NSLOT_L = (SLW+1)'(NSLOT);

  pk_state_e        pk_state;
  logic [SLW-1:0]   pack_cnt;
  logic [WIDTH-1:0] pack_acc;

  logic             accept;
  logic [WIDTH-1:0] src_word;
  logic [WIDTH-1:0] dep_word;
  logic [WIDTH-1:0] repl_word;
  logic [WIDTH-1:0] op_word;
  logic [WIDTH-1:0] pack_base;
  logic [WIDTH-1:0] pack_word;
  logic [SLW-1:0]   pack_slot;
  logic [SLW:0]     fill;
  logic             emit;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Out-of-range selects (non power-of-two NSRC) read as zero.
  always_comb begin
    src_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(in_sel) == i) begin
        src_word = in_src[i*WIDTH +: WIDTH];
      end
    end
  end

  dbm_slot_insert #(
    .WIDTH (WIDTH),
    .SLOTW (SLOTW),
    .NSLOT (NSLOT),
    .SLW   (SLW)
  ) u_dep_insert (
    .word   (src_word),
    .slot   (in_slot),
    .data   (in_byte),
    .result (dep_word)
  );

  always_comb begin
    repl_word = src_word;
    for (int k = 0; k < NSLOT; k++) begin
      repl_word[WIDTH-1-k*SLOTW -: SLOTW] = in_byte;
    end
  end

  always_comb begin
    case (in_op)
      OP_DEPOSIT: op_word = dep_word;
      OP_REPL:    op_word = repl_word;
      default:    op_word = src_word;
    endcase
  end

  // A fresh pack starts from an all-zero word so unfilled slots and the tail emit as 0.
  assign pack_slot = (pk_state == PK_FILL) ? pack_cnt : '0;
  assign pack_base = (pk_state == PK_FILL) ? pack_acc : '0;
  assign fill      = {1'b0, pack_slot} + (SLW+1)'(1);
  assign emit      = in_flush || (fill == NSLOT_L);

  dbm_slot_insert #(
    .WIDTH (WIDTH),
    .SLOTW (SLOTW),
    .NSLOT (NSLOT),
    .SLW   (SLW)
  ) u_pack_insert (
    .word   (pack_base),
    .slot   (pack_slot),
    .data   (in_byte),
    .result (pack_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      pk_state  <= PK_IDLE;
      pack_cnt  <= '0;
      pack_acc  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_op == OP_PACK) begin
          if (emit) begin
            out_valid <= 1'b1;
            out_data  <= pack_word;
            out_count <= fill;
            pk_state  <= PK_IDLE;
            pack_cnt  <= '0;
            pack_acc  <= '0;
          end else begin
            pk_state  <= PK_FILL;
            pack_cnt  <= fill[SLW-1:0];
            pack_acc  <= pack_word;
          end
        end else begin
          // Any other op abandons a partial pack.
          out_valid <= 1'b1;
          out_data  <= op_word;
          out_count <= '0;
          pk_state  <= PK_IDLE;
          pack_cnt  <= '0;
          pack_acc  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbm_slot_engine.sv
// Scoreboarded bench for dbm_slot_engine: directed corner cases then randomized traffic with random backpressure.
module tb_dbm_slot_engine;

  localparam int W  = 36;
  localparam int S  = 7;
  localparam int N  = 5;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [2:0]    in_sel;
  logic [2:0]    in_slot;
  logic [6:0]    in_byte;
  logic          in_flush;
  logic [NS*W-1:0] in_src;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_count;

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   c;
  } exp_t;

  exp_t        sb[$];
  logic [6:0]  pq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rnd_en = 0;

  dbm_slot_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_sel    (in_sel),
    .in_slot   (in_slot),
    .in_byte   (in_byte),
    .in_flush  (in_flush),
    .in_src    (in_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Word bit b (0 = MSB) lives at vector index W-1-b; byte bit 0 of the slot is the byte's MSB.
  function automatic logic [W-1:0] put_slot(input logic [W-1:0] w, input int k, input logic [6:0] b);
    for (int j = 0; j < S; j++) w[W-1-(k*S+j)] = b[S-1-j];
    return w;
  endfunction

  task automatic push_exp(input logic [W-1:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c[3:0];
    sb.push_back(e);
  endtask

  task automatic model(input int op, input int sel, input int slot, input logic [6:0] b,
                       input bit flush, input logic [NS*W-1:0] src);
    logic [W-1:0] sw, w;
    sw = src[sel*W +: W];
    case (op)
      0: begin push_exp(sw, 0); pq.delete(); end
      1: begin push_exp((slot < N) ? put_slot(sw, slot, b) : sw, 0); pq.delete(); end
      2: begin
        w = sw;
        for (int k = 0; k < N; k++) w = put_slot(w, k, b);
        push_exp(w, 0);
        pq.delete();
      end
      default: begin
        pq.push_back(b);
        if (flush || pq.size() == N) begin
          w = '0;
          for (int k = 0; k < pq.size(); k++) w = put_slot(w, k, pq[k]);
          push_exp(w, pq.size());
          pq.delete();
        end
      end
    endcase
  endtask

  int last_acc;

  // Called just after a posedge; returns 1 ns after the accepting edge.
  task automatic send(input int op, input int sel, input int slot, input logic [6:0] b, input bit flush);
    bit acc = 0;
    int n = 0;
    in_op = op[1:0]; in_sel = sel[2:0]; in_slot = slot[2:0]; in_byte = b; in_flush = flush;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk);
      n++;
    end
    if (acc) begin
      last_acc = cyc;
      model(op, sel, slot, b, flush, in_src);
    end
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      errors++; checks++;
      $display("FAIL accept_timeout act=no_accept exp=accept op=%0d", op);
    end
  endtask

  task automatic set_src(input int i, input logic [W-1:0] v);
    in_src[i*W +: W] = v;
  endtask

  task automatic rand_src();
    logic [63:0] r;
    for (int i = 0; i < NS; i++) begin
      r = {$urandom(), $urandom()};
      in_src[i*W +: W] = r[W-1:0];
    end
  endtask

  task automatic do_reset_cycles();
    rst = 1'b1;
    sb.delete();
    pq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: scoreboard pop on every transfer, plus hold-stability under stall.
  logic [W-1:0] held_d;
  logic [3:0]   held_c;
  bit           held_v = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 0;
      end else begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
          held_v = 0;
          if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_output act=%h/%0d exp=none", out_data, out_count);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_count", out_count, e.c);
          end
        end else if (out_valid) begin
          if (held_v) begin
            chk("hold_data", out_data, held_d);
            chk("hold_count", out_count, held_c);
          end
          held_v = 1; held_d = out_data; held_c = out_count;
        end else begin
          held_v = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rnd_en) begin
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; in_valid = 0; in_op = 0; in_sel = 0; in_slot = 0; in_byte = 0;
    in_flush = 0; in_src = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_count", out_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SEL with one-cycle latency
    rand_src();
    set_src(3, 36'o123456701234);
    send(0, 3, 0, 0, 0);
    @(negedge clk);
    chk("sel_latency_valid", out_valid, 1);
    chk("sel_data_direct", out_data, 36'o123456701234);
    @(posedge clk); #1;

    // DEPOSIT in range and out of range
    set_src(0, 36'o777777777777);
    send(1, 0, 2, 7'o000, 0);
    send(1, 0, 5, 7'o000, 0);
    // REPL with tail bit set
    v = 36'o000000000001;
    set_src(4, v);
    send(2, 4, 0, 7'o123, 0);
    drain();

    // PACK full word, then partial flush
    for (int i = 1; i <= 5; i++) send(3, 0, 0, i[6:0], 0);
    @(negedge clk);
    chk("pack5_valid", out_valid, 1);
    @(posedge clk); #1;
    send(3, 0, 0, 7'd1, 0);
    send(3, 0, 0, 7'd2, 0);
    send(3, 0, 0, 7'd3, 1);
    drain();

    // Backpressure: output held, new request waits, nothing lost
    out_ready = 1'b0;
    rand_src();
    send(0, 1, 0, 0, 0);
    fork
      send(2, 6, 0, 7'o055, 0);
    join_none
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    for (int i = 0; i < 4; i++) begin
      int prev;
      prev = last_acc;
      send(1, i, i, i[6:0] + 7'd9, 0);
      chk("b2b_one_per_cycle", last_acc - prev, 1);
    end
    drain();

    // Abort by SEL: next pack restarts at slot 0
    send(3, 0, 0, 7'o011, 0);
    send(3, 0, 0, 7'o022, 0);
    send(0, 5, 0, 0, 0);
    send(3, 0, 0, 7'o033, 1);
    drain();

    // Abort by reset
    send(3, 0, 0, 7'o044, 0);
    send(3, 0, 0, 7'o066, 0);
    do_reset_cycles();
    chk("rst_pack_cnt", dut.pack_cnt, 0);
    chk("rst_no_output", out_valid, 0);
    send(3, 0, 0, 7'o077, 1);
    drain();

    // Asynchronous reset mid-cycle while stalled
    out_ready = 1'b0;
    send(0, 2, 0, 0, 0);
    #3;
    rst = 1'b1;
    sb.delete();
    pq.delete();
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_count", out_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Random traffic with random backpressure
    rnd_en = 1;
    for (int i = 0; i < 300; i++) begin
      rand_src();
      send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
           7'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_en = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
